// File: rtl/router_mode_sequencer.sv
// Schedule-table driven mode/enable sequencer for a cluster of mesh routers.
// Steps through up to DEPTH entries, holding each for max(hold,1) cycles.
module router_mode_sequencer #(
  parameter int NUM_ROUTERS = 4,
  parameter int DEPTH       = 8,
  parameter int HOLD_WIDTH  = 8,
  parameter int MODE_WIDTH  = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              cfg_we,
  input  logic [$clog2(DEPTH)-1:0]          cfg_addr,
  input  logic [NUM_ROUTERS*MODE_WIDTH-1:0] cfg_mode,
  input  logic [NUM_ROUTERS-1:0]            cfg_en,
  input  logic [HOLD_WIDTH-1:0]             cfg_hold,
  input  logic [$clog2(DEPTH):0]            num_entries,
  input  logic                              loop_i,
  input  logic                              start_i,
  input  logic                              abort_i,
  output logic [NUM_ROUTERS*MODE_WIDTH-1:0] router_mode_o,
  output logic [NUM_ROUTERS-1:0]            src_enable_o,
  output logic [$clog2(DEPTH)-1:0]          entry_idx_o,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int MW = NUM_ROUTERS * MODE_WIDTH;
  localparam logic [MODE_WIDTH-1:0] MAX_LEGAL = MODE_WIDTH'(10);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state;
  logic [HOLD_WIDTH-1:0]  hold_cnt;
  logic [CW-1:0]          n_lat;
  logic                   loop_lat;

  logic [MW-1:0]          mode_tab [DEPTH];
  logic [NUM_ROUTERS-1:0] en_tab   [DEPTH];
  logic [HOLD_WIDTH-1:0]  hold_tab [DEPTH];

  logic                   last_entry;
  logic [AW-1:0]          ld_idx;
  logic                   bypass;
  logic [MW-1:0]          ld_mode;
  logic [NUM_ROUTERS-1:0] ld_en_raw;
  logic [NUM_ROUTERS-1:0] ld_en;
  logic [NUM_ROUTERS-1:0] ld_ill;
  logic [HOLD_WIDTH-1:0]  ld_hold_raw;
  logic [HOLD_WIDTH-1:0]  ld_hold;
  logic [CW-1:0]          n_clamped;

  always_ff @(posedge clk) begin
    if (cfg_we && state != RUN) begin
      mode_tab[cfg_addr] <= cfg_mode;
      en_tab[cfg_addr]   <= cfg_en;
      hold_tab[cfg_addr] <= cfg_hold;
    end
  end

  always_comb begin
    last_entry = (({1'b0, entry_idx_o} + CW'(1)) == n_lat);
    ld_idx     = (state == RUN && !last_entry) ? entry_idx_o + AW'(1) : '0;
    // A write coinciding with start must be seen by the entry-0 load.
    bypass     = cfg_we && (state != RUN) && (cfg_addr == ld_idx);
    ld_mode     = bypass ? cfg_mode : mode_tab[ld_idx];
    ld_en_raw   = bypass ? cfg_en   : en_tab[ld_idx];
    ld_hold_raw = bypass ? cfg_hold : hold_tab[ld_idx];
    ld_ill = '0;
    for (int unsigned i = 0; i < NUM_ROUTERS; i++) begin
      ld_ill[i] = (ld_mode[i*MODE_WIDTH +: MODE_WIDTH] > MAX_LEGAL);
    end
    ld_en     = ld_en_raw & ~ld_ill;
    ld_hold   = (ld_hold_raw == '0) ? HOLD_WIDTH'(1) : ld_hold_raw;
    n_clamped = (num_entries > CW'(DEPTH)) ? CW'(DEPTH) : num_entries;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      router_mode_o <= '0;
      src_enable_o  <= '0;
      entry_idx_o   <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
      hold_cnt      <= '0;
      n_lat         <= '0;
      loop_lat      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          router_mode_o <= '0;
          src_enable_o  <= '0;
          entry_idx_o   <= '0;
          busy_o        <= 1'b0;
          done_o        <= 1'b0;
          if (start_i) begin
            if (n_clamped == '0) begin
              state  <= DONE;
              done_o <= 1'b1;
            end else begin
              state         <= RUN;
              busy_o        <= 1'b1;
              n_lat         <= n_clamped;
              loop_lat      <= loop_i;
              router_mode_o <= ld_mode;
              src_enable_o  <= ld_en;
              entry_idx_o   <= ld_idx;
              hold_cnt      <= ld_hold;
              err_o         <= err_o | (|ld_ill);
            end
          end
        end
        RUN: begin
          if (abort_i) begin
            state         <= IDLE;
            busy_o        <= 1'b0;
            router_mode_o <= '0;
            src_enable_o  <= '0;
            entry_idx_o   <= '0;
          end else if (hold_cnt == HOLD_WIDTH'(1)) begin
            if (last_entry && !loop_lat) begin
              state         <= DONE;
              done_o        <= 1'b1;
              busy_o        <= 1'b0;
              router_mode_o <= '0;
              src_enable_o  <= '0;
              entry_idx_o   <= '0;
            end else begin
              // ld_idx already wraps to 0 after the last entry when looping.
              router_mode_o <= ld_mode;
              src_enable_o  <= ld_en;
              entry_idx_o   <= ld_idx;
              hold_cnt      <= ld_hold;
              err_o         <= err_o | (|ld_ill);
            end
          end else begin
            hold_cnt <= hold_cnt - HOLD_WIDTH'(1);
          end
        end
        DONE: begin
          state         <= IDLE;
          done_o        <= 1'b0;
          busy_o        <= 1'b0;
          router_mode_o <= '0;
          src_enable_o  <= '0;
          entry_idx_o   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_router_mode_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic, compared each
// cycle against a queue-based model that expands the schedule cycle by cycle.
module tb_router_mode_sequencer;

  localparam int NR = 4;
  localparam int D  = 8;
  localparam int HW = 8;
  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [15:0] cfg_mode = '0;
  logic [3:0]  cfg_en = '0;
  logic [7:0]  cfg_hold = '0;
  logic [3:0]  num_entries = '0;
  logic        loop_i = 1'b0;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [15:0] router_mode_o;
  logic [3:0]  src_enable_o;
  logic [2:0]  entry_idx_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  router_mode_sequencer #(
    .NUM_ROUTERS(NR),
    .DEPTH(D),
    .HOLD_WIDTH(HW),
    .MODE_WIDTH(MW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_mode(cfg_mode), .cfg_en(cfg_en), .cfg_hold(cfg_hold),
    .num_entries(num_entries), .loop_i(loop_i), .start_i(start_i),
    .abort_i(abort_i), .router_mode_o(router_mode_o),
    .src_enable_o(src_enable_o), .entry_idx_o(entry_idx_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [15:0] mode;
    logic [3:0]  en;
    logic [2:0]  idx;
    logic        ill;
  } slot_t;

  logic [15:0] t_mode [D];
  logic [3:0]  t_en   [D];
  logic [7:0]  t_hold [D];
  slot_t       q[$];
  slot_t       cur;
  int          phase = 0;   // 0 idle, 1 running, 2 done pulse
  int          m_n = 0;
  bit          m_loop = 1'b0;
  logic [15:0] e_mode = '0;
  logic [3:0]  e_en = '0;
  logic [2:0]  e_idx = '0;
  logic        e_busy = 1'b0;
  logic        e_done = 1'b0;
  logic        e_err = 1'b0;

  // Unroll the active schedule into one queue slot per output cycle.
  function automatic void expand();
    for (int e = 0; e < m_n; e++) begin
      slot_t s;
      logic [15:0] m;
      int h;
      m = t_mode[e];
      s.mode = m;
      s.en   = t_en[e];
      s.idx  = 3'(e);
      s.ill  = 1'b0;
      for (int r = 0; r < NR; r++) begin
        if (m[r*4 +: 4] > 4'd10) begin
          s.en[r] = 1'b0;
          s.ill   = 1'b1;
        end
      end
      h = (t_hold[e] == 8'd0) ? 1 : int'(t_hold[e]);
      for (int k = 0; k < h; k++) q.push_back(s);
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase = 0;
      q.delete();
      e_err = 1'b0;
    end else begin
      if (cfg_we && phase != 1) begin
        t_mode[cfg_addr] = cfg_mode;
        t_en[cfg_addr]   = cfg_en;
        t_hold[cfg_addr] = cfg_hold;
      end
      case (phase)
        0: if (start_i) begin
          int n;
          n = (num_entries > 4'd8) ? 8 : int'(num_entries);
          if (n == 0) phase = 2;
          else begin
            m_n = n;
            m_loop = loop_i;
            q.delete();
            expand();
            cur = q.pop_front();
            phase = 1;
          end
        end
        1: begin
          if (abort_i) begin
            phase = 0;
            q.delete();
          end else if (q.size() > 0) cur = q.pop_front();
          else if (m_loop) begin
            expand();
            cur = q.pop_front();
          end else phase = 2;
        end
        default: phase = 0;
      endcase
    end
    if (phase == 1) begin
      e_mode = cur.mode;
      e_en   = cur.en;
      e_idx  = cur.idx;
      e_err  = e_err | cur.ill;
    end else begin
      e_mode = '0;
      e_en   = '0;
      e_idx  = '0;
    end
    e_busy = (phase == 1);
    e_done = (phase == 2);
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("mode", 32'(router_mode_o), 32'(e_mode));
      chk("en",   32'(src_enable_o),  32'(e_en));
      chk("idx",  32'(entry_idx_o),   32'(e_idx));
      chk("busy", 32'(busy_o),        32'(e_busy));
      chk("done", 32'(done_o),        32'(e_done));
      chk("err",  32'(err_o),         32'(e_err));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wr(input int a, input logic [15:0] m, input logic [3:0] en, input logic [7:0] h);
    cfg_we = 1'b1; cfg_addr = 3'(a); cfg_mode = m; cfg_en = en; cfg_hold = h;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic go(input int n, input bit lp);
    num_entries = 4'(n); loop_i = lp; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy_o || done_o) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy_o || done_o) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: timeout busy=%0b done=%0b expected idle", busy_o, done_o);
    end
  endtask

  function automatic logic [15:0] rnd_mode();
    logic [15:0] m;
    for (int r = 0; r < NR; r++) begin
      if ($urandom_range(0, 9) == 0) m[r*4 +: 4] = 4'($urandom_range(11, 15));
      else m[r*4 +: 4] = 4'($urandom_range(0, 10));
    end
    return m;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_mode", 32'(router_mode_o), 32'h0);
    chk("reset_en",   32'(src_enable_o),  32'h0);
    chk("reset_busy", 32'(busy_o),        32'h0);
    chk("reset_err",  32'(err_o),         32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Unicast: each router SOUTH in turn, 50 cycles each.
    for (int i = 0; i < 4; i++) wr(i, 16'(2) << (4 * i), 4'(1 << i), 8'd50);
    go(4, 1'b0);
    chk("uni_first_en",   32'(src_enable_o),  32'h1);
    chk("uni_first_mode", 32'(router_mode_o), 32'h0002);
    repeat (49) @(negedge clk);
    chk("uni_e0_tail", 32'(src_enable_o), 32'h1);
    @(negedge clk);
    chk("uni_e1_en",   32'(src_enable_o),  32'h2);
    chk("uni_e1_mode", 32'(router_mode_o), 32'h0020);
    repeat (149) @(negedge clk);
    chk("uni_e3_en",  32'(src_enable_o), 32'h8);
    chk("uni_e3_idx", 32'(entry_idx_o),  32'h3);
    @(negedge clk);
    chk("uni_done",    32'(done_o),       32'h1);
    chk("uni_done_en", 32'(src_enable_o), 32'h0);
    @(negedge clk);
    chk("uni_done_end", 32'(done_o), 32'h0);

    // Loop with holds 3 and 0: period 4, then abort.
    wr(0, 16'h0001, 4'b0001, 8'd3);
    wr(1, 16'h0040, 4'b0100, 8'd0);
    go(2, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      chk("loop_en", 32'(src_enable_o), ((k - 1) % 4 == 3) ? 32'h4 : 32'h1);
      if (k < 8) @(negedge clk);
    end
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    chk("abort_en",   32'(src_enable_o), 32'h0);
    chk("abort_busy", 32'(busy_o),       32'h0);
    chk("abort_done", 32'(done_o),       32'h0);
    @(negedge clk);
    chk("abort_nodone", 32'(done_o), 32'h0);

    // Empty schedule.
    go(0, 1'b0);
    chk("empty_done", 32'(done_o), 32'h1);
    chk("empty_busy", 32'(busy_o), 32'h0);
    @(negedge clk);
    chk("empty_done_end", 32'(done_o), 32'h0);

    // Illegal code 12 on router 2.
    wr(0, 16'h0C00, 4'b1111, 8'd2);
    go(1, 1'b0);
    chk("ill_mode", 32'(router_mode_o), 32'h0C00);
    chk("ill_en",   32'(src_enable_o),  32'hB);
    chk("ill_err",  32'(err_o),         32'h1);
    wait_idle(20);
    chk("ill_err_sticky", 32'(err_o), 32'h1);

    // Writes during RUN are ignored; the same write in IDLE takes effect.
    wr(0, 16'h1111, 4'b1111, 8'd4);
    wr(1, 16'h2222, 4'b0011, 8'd4);
    go(2, 1'b0);
    wr(1, 16'h3333, 4'b0101, 8'd4);
    repeat (4) @(negedge clk);
    chk("runwr_mode", 32'(router_mode_o), 32'h2222);
    chk("runwr_en",   32'(src_enable_o),  32'h3);
    wait_idle(20);
    wr(1, 16'h3333, 4'b0101, 8'd4);
    go(2, 1'b0);
    repeat (5) @(negedge clk);
    chk("idlewr_mode", 32'(router_mode_o), 32'h3333);
    chk("idlewr_en",   32'(src_enable_o),  32'h5);
    wait_idle(20);

    // Write and start in the same cycle.
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_mode = 16'h0404; cfg_en = 4'b0010; cfg_hold = 8'd1;
    num_entries = 4'd1; loop_i = 1'b0; start_i = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0; start_i = 1'b0;
    chk("bypass_mode", 32'(router_mode_o), 32'h0404);
    chk("bypass_en",   32'(src_enable_o),  32'h2);
    wait_idle(20);

    // Random traffic.
    for (int i = 0; i < D; i++) wr(i, rnd_mode(), 4'($urandom), 8'($urandom_range(0, 5)));
    for (int c = 0; c < 2500; c++) begin
      cfg_we      = ($urandom_range(0, 9) < 3);
      cfg_addr    = 3'($urandom_range(0, 7));
      cfg_mode    = rnd_mode();
      cfg_en      = 4'($urandom);
      cfg_hold    = 8'($urandom_range(0, 5));
      start_i     = ($urandom_range(0, 9) == 0);
      num_entries = 4'($urandom_range(0, 15));
      loop_i      = ($urandom_range(0, 9) < 3);
      abort_i     = ($urandom_range(0, 49) == 0);
      @(negedge clk);
    end
    cfg_we = 1'b0; start_i = 1'b0; abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    wait_idle(20);

    // Asynchronous reset in the middle of a looping run.
    wr(0, 16'h0C21, 4'b1111, 8'd3);
    wr(1, 16'h0043, 4'b0110, 8'd2);
    go(2, 1'b1);
    repeat (5) @(negedge clk);
    chk("prereset_busy", 32'(busy_o), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_mode", 32'(router_mode_o), 32'h0);
    chk("areset_en",   32'(src_enable_o),  32'h0);
    chk("areset_busy", 32'(busy_o),        32'h0);
    chk("areset_idx",  32'(entry_idx_o),   32'h0);
    chk("areset_err",  32'(err_o),         32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_busy", 32'(busy_o), 32'h0);
    chk("post_reset_err",  32'(err_o),  32'h0);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
